// File: rtl/audio_sample_packetizer_if.sv
// Audio sample input handshake plus the packet-scheduler port of the audio sample packetizer.
// master = source/scheduler side, slave = packetizer.
interface audio_sample_packetizer_if #(
    parameter int CHANNEL_COUNT = 2,
    parameter int SAMPLE_WIDTH  = 24
);
    logic                                        audio_sample_valid;
    logic                                        audio_sample_ready;
    logic [CHANNEL_COUNT-1:0][SAMPLE_WIDTH-1:0]  audio_sample_word;
    logic                                        packet_pending;
    logic                                        packet_enable;
    logic [23:0]                                 header;
    logic [3:0][55:0]                            sub;
    logic                                        overflow;

    modport master (
        output audio_sample_valid, audio_sample_word, packet_enable,
        input  audio_sample_ready, packet_pending, header, sub, overflow
    );

    modport slave (
        input  audio_sample_valid, audio_sample_word, packet_enable,
        output audio_sample_ready, packet_pending, header, sub, overflow
    );
endinterface

// File: rtl/audio_sample_packetizer.sv
// L-PCM sample FIFO formatted into HDMI Audio Sample Packets (layout 0 / layout 1) with IEC 60958
// channel status. Optional macro AUDIO_SAMPLE_DROP_EN: drop-on-full with sticky overflow flag.
module audio_sample_packetizer #(
    parameter int         CHANNEL_COUNT      = 2,
    parameter int         SAMPLE_WIDTH       = 24,
    parameter int         FIFO_DEPTH         = 8,
    parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0000,
    parameter logic [3:0] WORD_LENGTH        = 4'b1011
) (
    input  logic                    clk_pixel,
    input  logic                    reset,
    audio_sample_packetizer_if.slave bus
);
    localparam bit              LAYOUT  = (CHANNEL_COUNT > 2);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef logic [CHANNEL_COUNT-1:0][23:0] entry_t;

    entry_t           mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [7:0]       fc_r;
    logic [CW-1:0]    n_s;
    logic [8:0]       fc_sum_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    entry_t           aligned_s;
    logic [3:0]       present_s;
    logic [3:0]       b_flag_s;
    logic [3:0][55:0] sub_s;

    function automatic logic cs_bit(input logic [7:0] idx, input logic [3:0] chan_num);
        logic b;
        if (idx == 8'd2) b = 1'b1;
        else if (idx >= 8'd20 && idx <= 8'd23) b = chan_num[idx[1:0]];
        else if (idx >= 8'd24 && idx <= 8'd27) b = SAMPLING_FREQUENCY[idx[1:0]];
        else if (idx >= 8'd32 && idx <= 8'd35) b = WORD_LENGTH[idx[1:0]];
        else b = 1'b0;
        return b;
    endfunction

    // Even parity over the 24-bit word and the C, U, V bits (U and V are always 0 here).
    function automatic logic sub_parity(input logic [23:0] word, input logic cs);
        return ^{word, cs, 1'b0, 1'b0};
    endfunction

    assign full_s   = (count_r == DEPTH_C);
    assign pop_s    = bus.packet_enable && (count_r != '0);
    assign fc_sum_s = {1'b0, fc_r} + 9'(n_s);

`ifdef AUDIO_SAMPLE_DROP_EN
    logic overflow_r;
    assign bus.audio_sample_ready = 1'b1;
    assign push_s = bus.audio_sample_valid && (!full_s || pop_s);
    assign bus.overflow = overflow_r;

    // Sticky drop flag, cleared only by reset
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) overflow_r <= 1'b0;
        else if (bus.audio_sample_valid && !push_s) overflow_r <= 1'b1;
    end
`else
    assign bus.audio_sample_ready = !full_s;
    assign push_s = bus.audio_sample_valid && !full_s;
    assign bus.overflow = 1'b0;
`endif

    // Number of FIFO-head samples carried by (and popped with) the current packet
    always_comb begin
        if (count_r == '0) n_s = '0;
        else if (LAYOUT) n_s = CW'(1);
        else if (count_r > CW'(4)) n_s = CW'(4);
        else n_s = count_r;
    end

    // MSB-align every channel into its 24-bit field
    always_comb begin
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            aligned_s[c] = 24'(bus.audio_sample_word[c]) << (24 - SAMPLE_WIDTH);
        end
    end

    // FIFO pointers, occupancy and IEC 60958 frame counter
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            fc_r     <= 8'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + n_s[AW-1:0];
                fc_r     <= (fc_sum_s >= 9'd192) ? 8'(fc_sum_s - 9'd192) : fc_sum_s[7:0];
            end
            count_r <= count_r + CW'(push_s) - (pop_s ? n_s : '0);
        end
    end

    // Sample storage; occupancy gates every read so no reset is needed
    always_ff @(posedge clk_pixel) begin
        if (push_s) mem_r[wr_ptr_r] <= aligned_s;
    end

    for (genvar k = 0; k < 4; k++) begin : g_sub
        localparam bit         HAS_PAIR = LAYOUT ? (2 * k + 1 < CHANNEL_COUNT) : 1'b1;
        localparam int         CH0      = (LAYOUT && HAS_PAIR) ? 2 * k : 0;
        localparam int         CH1      = (LAYOUT && HAS_PAIR) ? 2 * k + 1 : 1;
        localparam logic [3:0] NUM0     = LAYOUT ? 4'd0 : 4'd1;
        localparam logic [3:0] NUM1     = LAYOUT ? 4'd0 : 4'd2;

        logic [AW-1:0] idx_s;
        logic [8:0]    fsum_s;
        logic [7:0]    frame_s;
        logic [23:0]   w0_s;
        logic [23:0]   w1_s;
        logic          c0_s;
        logic          c1_s;

        // Layout 0 walks k entries past the head (wrapping with the pointer); layout 1 stays on the head
        assign idx_s   = LAYOUT ? rd_ptr_r : rd_ptr_r + AW'(k);
        assign fsum_s  = {1'b0, fc_r} + (LAYOUT ? 9'd0 : 9'(k));
        assign frame_s = (fsum_s >= 9'd192) ? 8'(fsum_s - 9'd192) : fsum_s[7:0];
        assign present_s[k] = LAYOUT ? (HAS_PAIR && (count_r != '0)) : (count_r > CW'(k));
        assign w0_s = mem_r[idx_s][CH0];
        assign w1_s = mem_r[idx_s][CH1];
        assign c0_s = cs_bit(frame_s, NUM0);
        assign c1_s = cs_bit(frame_s, NUM1);
        assign b_flag_s[k] = present_s[k] && (frame_s == 8'd0);
        assign sub_s[k] = present_s[k]
            ? {sub_parity(w1_s, c1_s), c1_s, 2'b00, sub_parity(w0_s, c0_s), c0_s, 2'b00, w1_s, w0_s}
            : 56'd0;
    end

    assign bus.packet_pending = (count_r != '0);
    assign bus.header = {b_flag_s, 4'b0000, 3'b000, LAYOUT, present_s, 8'h02};
    assign bus.sub    = sub_s;
endmodule

// File: tb/tb_audio_sample_packetizer.sv
// Randomized scoreboard bench for audio_sample_packetizer: a 2-channel layout-0 instance and a
// 6-channel, 16-bit, depth-4 layout-1 instance, each against a queue-based reference model.
module tb_audio_sample_packetizer;
    typedef logic [7:0][23:0] smp_t;
    typedef struct packed {
        logic [23:0]      header;
        logic [3:0][55:0] sub;
    } pkt_t;

    localparam int NCYC    = 2000;
    localparam int RST_CYC = 1200;
    localparam int TIMEOUT = 20000;

    logic clk_pixel = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    // IEC 60958 channel-status block for one channel, bit 0 first
    function automatic logic [191:0] cs_vec(input logic [3:0] chnum, input logic [3:0] sf,
                                            input logic [3:0] wl);
        logic [191:0] v;
        v         = '0;
        v[2]      = 1'b1;
        v[23:20]  = chnum;
        v[27:24]  = sf;
        v[35:32]  = wl;
        return v;
    endfunction

    // Expected packet from the buffered samples (h = FIFO head onwards), frame counter and count
    function automatic pkt_t model_pkt(input int lay, input int cc, input logic [3:0] sf,
                                       input logic [3:0] wl, input int fc, input int cnt,
                                       input smp_t h [4]);
        pkt_t         p;
        int           n;
        int           f;
        logic [3:0]   pres;
        logic [3:0]   bfl;
        logic [23:0]  a;
        logic [23:0]  b;
        logic         ca;
        logic         cb;
        logic [191:0] cs_a;
        logic [191:0] cs_b;
        p    = '0;
        pres = '0;
        bfl  = '0;
        if (cnt == 0) n = 0;
        else if (lay == 1) n = 1;
        else n = (cnt < 4) ? cnt : 4;
        cs_a = cs_vec((lay == 1) ? 4'd0 : 4'd1, sf, wl);
        cs_b = cs_vec((lay == 1) ? 4'd0 : 4'd2, sf, wl);
        for (int k = 0; k < 4; k++) begin
            f = 0;
            a = '0;
            b = '0;
            if (lay == 0 && k < n) begin
                f = (fc + k) % 192;
                a = h[k][0];
                b = h[k][1];
                pres[k] = 1'b1;
            end else if (lay == 1 && n == 1 && 2 * k < cc) begin
                f = fc;
                a = h[0][2 * k];
                b = h[0][2 * k + 1];
                pres[k] = 1'b1;
            end
            if (pres[k]) begin
                ca = cs_a[f];
                cb = cs_b[f];
                bfl[k] = (f == 0);
                p.sub[k] = {^{b, cb}, cb, 1'b0, 1'b0, ^{a, ca}, ca, 1'b0, 1'b0, b, a};
            end
        end
        p.header = {bfl, 4'b0000, 3'b000, 1'(lay), pres, 8'h02};
        return p;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int         CC  = (g == 0) ? 2 : 6;
        localparam int         SW  = (g == 0) ? 24 : 16;
        localparam int         DEP = (g == 0) ? 8 : 4;
        localparam int         LAY = (CC > 2) ? 1 : 0;
        localparam logic [3:0] SF  = (g == 0) ? 4'b0000 : 4'b0010;
        localparam logic [3:0] WL  = (g == 0) ? 4'b1011 : 4'b0010;

        logic rst_s = 1'b1;
        bit   done  = 1'b0;
        pkt_t expq [$];
        smp_t mq [$];

        audio_sample_packetizer_if #(.CHANNEL_COUNT(CC), .SAMPLE_WIDTH(SW)) bus ();

        audio_sample_packetizer #(
            .CHANNEL_COUNT(CC), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEP),
            .SAMPLING_FREQUENCY(SF), .WORD_LENGTH(WL)
        ) dut (
            .clk_pixel (clk_pixel),
            .reset     (rst_s),
            .bus       (bus)
        );

        // Stimulus and reference model; expected packets go to expq when a pop is issued
        initial begin : drive
            smp_t        s;
            smp_t        junk;
            smp_t        h [4];
            pkt_t        p;
            int          cnt;
            int          n;
            int          fc;
            int          pv;
            int          pe;
            bit          ovf;
            bit          v;
            bit          e;
            bit          pop;
            bit          push;
            bit          mready;
            logic [23:0] raw;
            fc  = 0;
            ovf = 1'b0;
            for (int k = 0; k < 4; k++) h[k] = '0;
            bus.audio_sample_valid = 1'b0;
            bus.packet_enable      = 1'b0;
            bus.audio_sample_word  = '0;
            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(negedge clk_pixel);
                cnt = mq.size();
`ifdef AUDIO_SAMPLE_DROP_EN
                mready = 1'b1;
`else
                mready = (cnt < DEP);
`endif
                checks++;
                if ({bus.audio_sample_ready, bus.packet_pending, bus.overflow} !== {mready, cnt != 0, ovf}) begin
                    errors++;
                    $display("FAIL status cfg%0d cyc%0d rdy/pend/ovf got %b required %b", g, cyc,
                             {bus.audio_sample_ready, bus.packet_pending, bus.overflow}, {mready, cnt != 0, ovf});
                end
                if (cnt == 0) begin
                    p = model_pkt(LAY, CC, SF, WL, fc, 0, h);
                    checks++;
                    if (bus.header !== p.header || bus.sub !== p.sub) begin
                        errors++;
                        $display("FAIL idle_pkt cfg%0d cyc%0d header got %h required %h sub got %h", g, cyc,
                                 bus.header, p.header, bus.sub);
                    end
                end
                if (cyc == 0 || cyc == RST_CYC + 1) rst_s = 1'b0;
                if (cyc == RST_CYC) begin
                    bus.audio_sample_valid = 1'b0;
                    bus.packet_enable      = 1'b0;
                    #3 rst_s = 1'b1;
                    #1;
                    checks++;
                    if (bus.packet_pending !== 1'b0 || bus.audio_sample_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL async_reset cfg%0d pend/rdy got %b%b required 01", g,
                                 bus.packet_pending, bus.audio_sample_ready);
                    end
                    mq.delete();
                    fc  = 0;
                    ovf = 1'b0;
                    continue;
                end
                if (cyc < 5) begin
                    v = 1'b1; e = 1'b0;
                end else if (cyc < 7) begin
                    v = 1'b0; e = 1'b1;
                end else if (cyc >= RST_CYC - 13 && cyc < RST_CYC - 3) begin
                    v = 1'b0; e = 1'b1;
                end else if (cyc >= RST_CYC - 3 && cyc < RST_CYC) begin
                    v = 1'b1; e = 1'b0;
                end else begin
                    case ((cyc / 150) % 3)
                        0:       begin pv = 85; pe = 20; end
                        1:       begin pv = 25; pe = 70; end
                        default: begin pv = 55; pe = 55; end
                    endcase
                    v = ($urandom_range(99) < pv);
                    e = ($urandom_range(99) < pe);
                end
                s = '0;
                for (int c = 0; c < CC; c++) begin
                    raw = 24'($urandom) & ((24'd1 << SW) - 24'd1);
                    bus.audio_sample_word[c] = SW'(raw);
                    s[c] = raw << (24 - SW);
                end
                bus.audio_sample_valid = v;
                bus.packet_enable      = e;
                pop = e && (cnt > 0);
                if (cnt == 0) n = 0;
                else if (LAY == 1) n = 1;
                else n = (cnt < 4) ? cnt : 4;
                if (pop) begin
                    for (int k = 0; k < 4; k++) h[k] = (k < n) ? mq[k] : '0;
                    expq.push_back(model_pkt(LAY, CC, SF, WL, fc, cnt, h));
                end
`ifdef AUDIO_SAMPLE_DROP_EN
                push = v && ((cnt < DEP) || pop);
                if (v && !push) ovf = 1'b1;
`else
                push = v && (cnt < DEP);
`endif
                if (pop) begin
                    for (int i = 0; i < n; i++) junk = mq.pop_front();
                    fc = (fc + n) % 192;
                end
                if (push) mq.push_back(s);
            end
            @(negedge clk_pixel);
            bus.packet_enable      = 1'b0;
            bus.audio_sample_valid = 1'b0;
            #3;
            checks++;
            if (expq.size() != 0) begin
                errors++;
                $display("FAIL drain cfg%0d expected packets left %0d required 0", g, expq.size());
            end
            done = 1'b1;
        end

        // Monitor: every consumed packet is compared against the next scoreboard entry
        initial begin : monitor
            pkt_t ex;
            pkt_t act;
            forever begin
                @(negedge clk_pixel);
                #2;
                if (bus.packet_pending === 1'b1 && bus.packet_enable === 1'b1) begin
                    act.header = bus.header;
                    act.sub    = bus.sub;
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL pkt cfg%0d unexpected packet header got %h required none", g, act.header);
                    end else begin
                        ex = expq.pop_front();
                        if (act !== ex) begin
                            errors++;
                            $display("FAIL pkt cfg%0d header got %h required %h sub got %h required %h", g,
                                     act.header, ex.header, act.sub, ex.sub);
                        end
                    end
                end
            end
        end
    end

    initial begin : finisher
        for (int t = 0; t < TIMEOUT && !(g_cfg[0].done && g_cfg[1].done); t++) @(posedge clk_pixel);
        checks++;
        if (!(g_cfg[0].done && g_cfg[1].done)) begin
            errors++;
            $display("FAIL timeout done got %b%b required 11", g_cfg[1].done, g_cfg[0].done);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
